// File: rtl/bounce_sprite.sv
// Bouncing rectangular sprite for the VGA pixel stage: moves once per frame inside
// vertical blank and produces a registered per-pixel mask and colour.
module bounce_sprite #(
    parameter int unsigned H_START   = 144,
    parameter int unsigned V_START   = 35,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned BOX_W     = 32,
    parameter int unsigned BOX_H     = 32,
    parameter int unsigned STEP      = 2,
    parameter logic [11:0] BOX_COLOR = 12'hF00,
    parameter logic [11:0] BG_COLOR  = 12'h00F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        bright,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        run,
    output logic [9:0]  box_x,
    output logic [9:0]  box_y,
    output logic        box_on,
    output logic [11:0] rgb,
    output logic        frame_tick,
    output logic        corner,
    output logic [7:0]  hit_count
);

    localparam int unsigned LIM_X     = H_ACTIVE - BOX_W;
    localparam int unsigned LIM_Y     = V_ACTIVE - BOX_H;
    localparam int unsigned TICK_LINE = V_START + V_ACTIVE;

    typedef enum logic [1:0] {WAIT_FRAME, MOVE_X, MOVE_Y, DONE} state_t;

    state_t      state, stateNext;
    logic        dirX, dirY, dirXNext, dirYNext;
    logic        bouncedX, bouncedXNext;
    logic [9:0]  boxXNext, boxYNext;
    logic [7:0]  hitNext;
    logic        cornerNext;
    logic [9:0]  lastV;
    logic [11:0] xStep, yStep;
    logic [10:0] hx, vy;
    logic        inBox;

    // One axis update at 11 bits: returns {bounce, newDir, newPos}.
    function automatic logic [11:0] stepAxis(input logic [9:0] pos, input logic dir,
                                             input logic [10:0] lim);
        logic [10:0] wide;
        wide = {1'b0, pos};
        if (dir) begin
            if (wide + 11'(STEP) >= lim) return {1'b1, 1'b0, lim[9:0]};
            else                         return {1'b0, 1'b1, 10'(wide + 11'(STEP))};
        end else begin
            if (wide <= 11'(STEP))       return {1'b1, 1'b1, 10'd0};
            else                         return {1'b0, 1'b0, 10'(wide - 11'(STEP))};
        end
    endfunction

    assign xStep = stepAxis(box_x, dirX, 11'(LIM_X));
    assign yStep = stepAxis(box_y, dirY, 11'(LIM_Y));

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= WAIT_FRAME;
            box_x     <= 10'((H_ACTIVE - BOX_W) / 2);
            box_y     <= 10'((V_ACTIVE - BOX_H) / 2);
            dirX      <= 1'b1;
            dirY      <= 1'b1;
            bouncedX  <= 1'b0;
            hit_count <= 8'd0;
            corner    <= 1'b0;
        end else begin
            state     <= stateNext;
            box_x     <= boxXNext;
            box_y     <= boxYNext;
            dirX      <= dirXNext;
            dirY      <= dirYNext;
            bouncedX  <= bouncedXNext;
            hit_count <= hitNext;
            corner    <= cornerNext;
        end
    end

    always_comb begin
        stateNext    = state;
        boxXNext     = box_x;
        boxYNext     = box_y;
        dirXNext     = dirX;
        dirYNext     = dirY;
        bouncedXNext = bouncedX;
        hitNext      = hit_count;
        cornerNext   = 1'b0;
        case (state)
            WAIT_FRAME: if (frame_tick && run) stateNext = MOVE_X;
            MOVE_X: begin
                boxXNext     = xStep[9:0];
                dirXNext     = xStep[10];
                bouncedXNext = xStep[11];
                if (xStep[11]) hitNext = satInc(hit_count);
                stateNext    = MOVE_Y;
            end
            MOVE_Y: begin
                boxYNext   = yStep[9:0];
                dirYNext   = yStep[10];
                if (yStep[11]) hitNext = satInc(hit_count);
                cornerNext = bouncedX && yStep[11];
                stateNext  = DONE;
            end
            DONE:    stateNext = WAIT_FRAME;
            default: stateNext = WAIT_FRAME;
        endcase
    end

    // Frame tick fires once when the line counter first reaches the blank line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_tick <= 1'b0;
            lastV      <= 10'd0;
        end else begin
            frame_tick <= pix_en && (vCount == 10'(TICK_LINE)) && (lastV != vCount);
            if (pix_en) lastV <= vCount;
        end
    end

    assign hx = {1'b0, hCount} - 11'(H_START);
    assign vy = {1'b0, vCount} - 11'(V_START);
    assign inBox = bright
                && ({1'b0, box_x} <= hx) && (hx < {1'b0, box_x} + 11'(BOX_W))
                && ({1'b0, box_y} <= vy) && (vy < {1'b0, box_y} + 11'(BOX_H));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            box_on <= 1'b0;
            rgb    <= 12'h000;
        end else if (pix_en) begin
            box_on <= inBox;
            rgb    <= inBox ? BOX_COLOR : (bright ? BG_COLOR : 12'h000);
        end
    end

endmodule

// File: tb/tb_bounce_sprite.sv
// Directed bench for bounce_sprite: default-size instance plus a small instance
// whose geometry makes corner bounces and hit_count saturation reachable quickly.
module tb_bounce_sprite;

    logic        clk = 1'b0;
    logic        reset;
    logic        pixEn, bright, run;
    logic [9:0]  hCount, vCount;
    logic [9:0]  boxX, boxY;
    logic        boxOn, frameTick, cornerO;
    logic [11:0] rgb;
    logic [7:0]  hitCount;

    logic        sPixEn, sBright, sRun;
    logic [9:0]  sHCount, sVCount;
    logic [9:0]  sBoxX, sBoxY;
    logic        sBoxOn, sFrameTick, sCorner;
    logic [11:0] sRgb;
    logic [7:0]  sHitCount;

    int checks = 0;
    int errors = 0;
    int tickCnt = 0;
    int cornerCnt = 0;
    int sCornerCnt = 0;
    int t0;

    always #5 clk = ~clk;

    bounce_sprite dut (
        .clk(clk), .reset(reset), .pix_en(pixEn), .bright(bright),
        .hCount(hCount), .vCount(vCount), .run(run),
        .box_x(boxX), .box_y(boxY), .box_on(boxOn), .rgb(rgb),
        .frame_tick(frameTick), .corner(cornerO), .hit_count(hitCount)
    );

    bounce_sprite #(
        .H_START(2), .V_START(2), .H_ACTIVE(48), .V_ACTIVE(48),
        .BOX_W(16), .BOX_H(16), .STEP(4)
    ) sDut (
        .clk(clk), .reset(reset), .pix_en(sPixEn), .bright(sBright),
        .hCount(sHCount), .vCount(sVCount), .run(sRun),
        .box_x(sBoxX), .box_y(sBoxY), .box_on(sBoxOn), .rgb(sRgb),
        .frame_tick(sFrameTick), .corner(sCorner), .hit_count(sHitCount)
    );

    always @(posedge clk) begin
        if (frameTick === 1'b1) tickCnt <= tickCnt + 1;
        if (cornerO === 1'b1)   cornerCnt <= cornerCnt + 1;
        if (sCorner === 1'b1)   sCornerCnt <= sCornerCnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Two pix_en lines ending on the blank line, then leave pix_en low.
    task automatic startFrame();
        @(negedge clk); pixEn = 1'b1; vCount = 10'd514;
        @(negedge clk); vCount = 10'd515;
        @(negedge clk); pixEn = 1'b0;
    endtask

    task automatic doFrame();
        startFrame();
        repeat (5) @(negedge clk);
    endtask

    task automatic sFrame();
        @(negedge clk); sPixEn = 1'b1; sVCount = 10'd49;
        @(negedge clk); sVCount = 10'd50;
        @(negedge clk); sPixEn = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        pixEn = 1'b0; bright = 1'b0; run = 1'b1; hCount = '0; vCount = '0;
        sPixEn = 1'b0; sBright = 1'b0; sRun = 1'b1; sHCount = '0; sVCount = '0;
        repeat (2) @(negedge clk);
        check("rst_box_x", 32'(boxX), 32'd304);
        check("rst_box_y", 32'(boxY), 32'd224);
        check("rst_rgb", 32'(rgb), 32'h000);
        check("rst_hits", 32'(hitCount), 32'd0);
        check("rst_tick", 32'(frameTick), 32'd0);
        check("rst_box_on", 32'(boxOn), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Reset arriving while the update sits in MOVE_Y
        startFrame();
        @(negedge clk);
        @(negedge clk);
        check("mid_x_moved", 32'(boxX), 32'd306);
        reset = 1'b0;
        #1;
        check("mid_rst_x", 32'(boxX), 32'd304);
        check("mid_rst_y", 32'(boxY), 32'd224);
        check("mid_rst_hits", 32'(hitCount), 32'd0);
        check("mid_rst_tick", 32'(frameTick), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        t0 = tickCnt;
        doFrame();
        check("f1_ticks", 32'(tickCnt - t0), 32'd1);
        check("f1_x", 32'(boxX), 32'd306);
        check("f1_y", 32'(boxY), 32'd226);
        check("f1_hits", 32'(hitCount), 32'd0);

        // y bounces at 448 on frame 112; x reaches 606 on frame 151
        repeat (150) doFrame();
        check("f151_x", 32'(boxX), 32'd606);
        check("f151_y", 32'(boxY), 32'd370);
        check("f151_hits", 32'(hitCount), 32'd1);
        doFrame();
        check("f152_x", 32'(boxX), 32'd608);
        check("f152_y", 32'(boxY), 32'd368);
        check("f152_hits", 32'(hitCount), 32'd2);
        doFrame();
        check("f153_x", 32'(boxX), 32'd606);
        check("f153_y", 32'(boxY), 32'd366);
        check("f153_hits", 32'(hitCount), 32'd2);
        check("main_no_corner", 32'(cornerCnt), 32'd0);

        // Pixel path around a centred sprite
        run = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bright = 1'b1; pixEn = 1'b1; hCount = 10'd448; vCount = 10'd259;
        @(negedge clk); pixEn = 1'b0; hCount = 10'd0;
        check("pix_in_on", 32'(boxOn), 32'd1);
        check("pix_in_rgb", 32'(rgb), 32'hF00);
        @(negedge clk);
        check("pix_hold_rgb", 32'(rgb), 32'hF00);
        pixEn = 1'b1; hCount = 10'd479;
        @(negedge clk);
        check("pix_right_in", 32'(rgb), 32'hF00);
        hCount = 10'd480;
        @(negedge clk);
        check("pix_right_out", 32'(rgb), 32'h00F);
        check("pix_right_on", 32'(boxOn), 32'd0);
        hCount = 10'd447;
        @(negedge clk);
        check("pix_left_out", 32'(rgb), 32'h00F);
        hCount = 10'd448; bright = 1'b0;
        @(negedge clk);
        pixEn = 1'b0;
        check("pix_dark_rgb", 32'(rgb), 32'h000);
        check("pix_dark_on", 32'(boxOn), 32'd0);

        // Frozen sprite still ticks every frame
        t0 = tickCnt;
        repeat (3) doFrame();
        check("frz_ticks", 32'(tickCnt - t0), 32'd3);
        check("frz_x", 32'(boxX), 32'd304);
        check("frz_y", 32'(boxY), 32'd224);

        // Small instance: limit 32 on both axes, start 16, step 4
        repeat (4) sFrame();
        check("s4_x", 32'(sBoxX), 32'd32);
        check("s4_y", 32'(sBoxY), 32'd32);
        check("s4_corner", 32'(sCornerCnt), 32'd1);
        check("s4_hits", 32'(sHitCount), 32'd2);
        sFrame();
        check("s5_x", 32'(sBoxX), 32'd28);
        check("s5_y", 32'(sBoxY), 32'd28);
        check("s5_hits", 32'(sHitCount), 32'd2);
        repeat (1007) sFrame();
        check("s1012_hits", 32'(sHitCount), 32'd254);
        check("s1012_x", 32'(sBoxX), 32'd32);
        check("s1012_corner", 32'(sCornerCnt), 32'd127);
        repeat (8) sFrame();
        check("s1020_hits", 32'(sHitCount), 32'd255);
        check("s1020_x", 32'(sBoxX), 32'd0);
        check("s1020_corner", 32'(sCornerCnt), 32'd128);
        repeat (8) sFrame();
        check("s1028_hits", 32'(sHitCount), 32'd255);
        check("s1028_y", 32'(sBoxY), 32'd32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bounce_sprite.md
Name: bounce_sprite

Overview:
- Upstream object generator for the VGA pixel stage; runs on the board clock next to the timing controller.
- Consumes the controller's hCount/vCount/bright and keeps a rectangular sprite moving, bouncing off the screen edges once per frame.
- Produces a registered per-pixel sprite mask and a 12-bit RGB word for the display stage, plus a frame tick and a bounce counter.

Parameters:
- H_START, 144, hCount value of the first visible column
- V_START, 35, vCount value of the first visible line
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height in lines
- BOX_W, 32, sprite width in pixels
- BOX_H, 32, sprite height in lines
- STEP, 2, pixels moved per axis per frame (1..BOX_W)
- BOX_COLOR, 12'hF00, sprite RGB
- BG_COLOR, 12'h00F, visible-area background RGB

Ports:
- clk  in  1  board clock
- reset  in  1  asynchronous, active-low reset
- pix_en  in  1  one-cycle pulse per pixel; hCount/vCount are valid on this cycle
- bright  in  1  visible-area flag from the timing controller
- hCount  in  10  horizontal counter
- vCount  in  10  vertical counter
- run  in  1  1 = move sprite each frame, 0 = freeze position
- box_x  out  10  sprite left edge, visible-area coordinates
- box_y  out  10  sprite top edge, visible-area coordinates
- box_on  out  1  current pixel is inside the sprite
- rgb  out  12  pixel colour {R[3:0],G[3:0],B[3:0]}
- frame_tick  out  1  one-cycle pulse at the start of vertical blank
- corner  out  1  one-cycle pulse when both axes bounce in the same update
- hit_count  out  8  wall bounces, saturating

Behaviour:
- Reset (reset=0, async): box_x=(H_ACTIVE-BOX_W)/2 (304), box_y=(V_ACTIVE-BOX_H)/2 (224).
- Reset also sets: dir_x=+, dir_y=+, box_on=0, rgb=0, frame_tick=0, corner=0, hit_count=0, FSM=WAIT_FRAME, last_v=0.
- Reset release mid-frame: no frame_tick until the next V_START+V_ACTIVE crossing.
- Frame tick:
  - Registered last_v updates on pix_en.
  - frame_tick=1 for one clk when pix_en=1, vCount==V_START+V_ACTIVE and last_v!=vCount.
  - Pulses regardless of run.
- FSM states: WAIT_FRAME, MOVE_X, MOVE_Y, DONE.
  - WAIT_FRAME -> MOVE_X the cycle after frame_tick if run=1; otherwise stay.
  - MOVE_X -> MOVE_Y -> DONE -> WAIT_FRAME, one clk each.
  - A full update completes in 3 clks, entirely inside vertical blank, so there is no tearing.
  - run dropping mid-update does not abort the update.
- MOVE_X (limit L=H_ACTIVE-BOX_W=608), arithmetic at 11 bits, no wrap:
  - dir + and box_x+STEP>=L: box_x=L, dir_x=-, bounce.
  - dir + otherwise: box_x+=STEP.
  - dir - and box_x<=STEP: box_x=0, dir_x=+, bounce.
  - dir - otherwise: box_x-=STEP.
- MOVE_Y: same rules with L=V_ACTIVE-BOX_H=448 on box_y/dir_y.
- Bounce accounting:
  - Each axis bounce increments hit_count by 1, saturating at 255.
  - If both axes bounced in one update, corner pulses 1 clk in DONE.
- Pixel path (1-clk latency, updated on pix_en only, held otherwise):
  - hx=hCount-H_START, vy=vCount-V_START.
  - box_on <= bright && box_x<=hx<box_x+BOX_W && box_y<=vy<box_y+BOX_H.
  - rgb <= BOX_COLOR if box_on-condition; else BG_COLOR if bright; else 12'h000.
  - When bright=0, box_on=0 and rgb=0.

Test Plan:
- Reset then release, no pix_en -> box_x=304, box_y=224, rgb=000, hit_count=0, frame_tick=0. Assert reset mid-update (state MOVE_Y) -> all values return to these immediately.
- run=1, drive one vCount crossing to 515 with pix_en -> single frame_tick pulse. 3 clks later box_x=306, box_y=226, no hit_count change.
- Preload by stepping to box_x=606, dir_x=+, one frame -> box_x=608, dir_x=-, hit_count+1. Next frame -> box_x=606.
- Drive a state where box_x=608 and box_y=448 are reached in the same update -> corner pulses once, hit_count+2. Next frame -> box_x=606, box_y=446.
- With box_x=304, box_y=224, bright=1, pix_en at hCount=448, vCount=259 -> next clk box_on=1, rgb=F00.
  - hCount=480 -> rgb=00F.
  - bright=0 -> rgb=000.
- run=0 across 3 frames -> 3 frame_tick pulses, box_x/box_y unchanged. hit_count forced to 255 then another bounce -> stays 255.
